serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell under a three-state controller.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             barrow,
    output logic             zero
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on the accepting edge
    // RUN   | one result bit per cycle, index idx, borrow carried in brw
    // DONE  | one-cycle done pulse; always returns to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int IW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] mask;
    logic [IW-1:0]    idx;
    logic             brw;
    logic             x;
    logic             y;
    logic             d;
    logic             bo;
    logic             last;

    // The single full-subtractor cell; operand bit idx sits at bit 0 of each shifter.
    always_comb begin
        x       = a_sh[0];
        y       = b_sh[0];
        d       = x ^ y ^ brw;
        bo      = (~x & y) | (~(x ^ y) & brw);
        mask    = WIDTH'(1) << idx;
        res_nxt = d ? (res | mask) : (res & ~mask);
        last    = (idx == IW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Published outputs only move on the RUN -> DONE edge, so they stay stable during a run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            brw    <= 1'b0;
            idx    <= '0;
            res    <= '0;
            diff   <= '0;
            barrow <= 1'b0;
            zero   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        brw  <= bin;
                        idx  <= '0;
                        res  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    brw  <= bo;
                    res  <= res_nxt;
                    if (last) begin
                        idx    <= '0;
                        diff   <= res_nxt;
                        barrow <= bo;
                        zero   <= (res_nxt == '0);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       barrow;
    logic       zero;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       bin1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       barrow1;
    logic       zero1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .barrow(barrow), .zero(zero)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .barrow(barrow1), .zero(zero1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       barrow;
        logic       zero;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction; borrow-out is a negative result.
    function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
        int         r;
        logic [8:0] o;
        r = int'(x) - int'(y) - int'(c);
        o[8]   = (r < 0);
        o[7:0] = r[7:0];
        return o;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op8(input string name, input logic [7:0] xa, input logic [7:0] xb,
                           input logic xc, input logic [7:0] ed, input logic eb, input logic ez);
        logic [7:0] prev;
        int         lat_bad;
        int         dchg;
        prev    = diff;
        lat_bad = 0;
        dchg    = 0;
        start = 1'b1;
        a     = xa;
        b     = xb;
        bin   = xc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            bin = 1'($urandom);
            if (busy !== (k <= 8)) lat_bad++;
            if (done !== (k == 9)) lat_bad++;
            if (busy === 1'b1 && done === 1'b1) lat_bad++;
            if (k <= 8 && diff !== prev) dchg++;
            if (k < 9) @(negedge clk);
        end
        chk({name, " latency"}, lat_bad, 0);
        chk({name, " hold"}, dchg, 0);
        chk({name, " diff"}, diff, ed);
        chk({name, " barrow"}, barrow, eb);
        chk({name, " zero"}, zero, ez);
        @(negedge clk);
    endtask

    initial begin
        vec_t       vt[7];
        logic [1:0] exp1[8];
        logic [8:0] e;
        logic [8:0] q[$];
        int         nd;
        int         bad;

        vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[3] = '{8'h37, 8'h37, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0};
        vt[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        exp1  = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

        // Reset with start asserted: reset wins.
        rst_n  = 1'b0;
        start  = 1'b1;
        a      = 8'h12;
        b      = 8'h34;
        bin    = 1'b1;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        bin1   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst diff", diff, 0);
        chk("rst barrow", barrow, 0);
        chk("rst zero", zero, 1);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst idle", busy, 0);

        for (int i = 0; i < 7; i++)
            run_op8($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].bin,
                    vt[i].diff, vt[i].barrow, vt[i].zero);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom);
            rb = (i % 8 == 0) ? ra : 8'($urandom);
            rc = 1'($urandom);
            e  = ref_sub(ra, rb, rc);
            run_op8($sformatf("rnd%0d", i), ra, rb, rc, e[7:0], e[8], e[7:0] == 8'h00);
        end

        // Start held high for 20 cycles, operands toggling every cycle:
        // accepts land every WIDTH+2 cycles starting with the first one.
        nd = 0;
        for (int n = 0; n < 32; n++) begin
            if (done === 1'b1) begin
                nd++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("held diff", diff, e[7:0]);
                    chk("held barrow", barrow, e[8]);
                end else begin
                    chk("held extra done", 1, 0);
                end
            end
            start = (n < 20);
            a     = 8'($urandom);
            b     = 8'($urandom);
            bin   = 1'($urandom);
            if (n < 20 && n % 10 == 0) q.push_back(ref_sub(a, b, bin));
            @(negedge clk);
        end
        start = 1'b0;
        chk("held done count", nd, 2);

        // Make diff nonzero, then reset in the middle of a run.
        run_op8("pre-abort", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        start = 1'b1;
        a     = 8'hA5;
        b     = 8'h11;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort diff", diff, 0);
        chk("abort barrow", barrow, 0);
        chk("abort zero", zero, 1);
        bad = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("abort quiet", bad, 0);
        run_op8("post-abort", 8'hC3, 8'h42, 1'b1, 8'h80, 1'b0, 1'b0);

        // WIDTH=1: exhaustive, done two cycles after start.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v      = 3'(i);
            a1     = v[2];
            b1     = v[1];
            bin1   = v[0];
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            chk($sformatf("w1 busy %0d", i), {busy1, done1}, 2'b10);
            @(negedge clk);
            chk($sformatf("w1 done %0d", i), {busy1, done1}, 2'b01);
            chk($sformatf("w1 result %0d", i), {barrow1, diff1}, exp1[i]);
            chk($sformatf("w1 zero %0d", i), zero1, (exp1[i][0] == 1'b0));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
